// File: rtl/counter_clock_downsample.sv
// Programmable counter-based clock divider: clk_r_o half-period is cmp+1 cycles of clk_i.
// Optional macro COUNTER_CLOCK_DOWNSAMPLE_VAL_SHADOW_EN latches val_i only at terminal count.
module counter_clock_downsample #(
  parameter int unsigned width_p  = 2,
  parameter bit          harden_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] val_i,
  output logic               clk_r_o
);

  localparam int unsigned W = width_p;

  logic [W-1:0] ctr_r;
  logic [W-1:0] cmp;
  logic         terminal;

  // >= rather than == so a shrinking ratio never lets the counter run past cmp and wrap
  assign terminal = (ctr_r >= cmp);

`ifdef COUNTER_CLOCK_DOWNSAMPLE_VAL_SHADOW_EN
  logic [W-1:0] val_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      val_r <= '0;
    end else if (terminal) begin
      val_r <= val_i;
    end
  end

  assign cmp = val_r;
`else
  assign cmp = val_i;
`endif

  generate
    if (harden_p) begin : g_hard
      // Explicit mux + flop split, mirroring the hardened cell wrapper structure
      logic [W-1:0] ctr_n;
      logic         clk_n;

      assign ctr_n = terminal ? W'(0) : (ctr_r + W'(1));
      assign clk_n = clk_r_o ^ terminal;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          ctr_r   <= '0;
          clk_r_o <= 1'b0;
        end else begin
          ctr_r   <= ctr_n;
          clk_r_o <= clk_n;
        end
      end
    end else begin : g_soft
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          ctr_r   <= '0;
          clk_r_o <= 1'b0;
        end else if (terminal) begin
          ctr_r   <= '0;
          clk_r_o <= ~clk_r_o;
        end else begin
          ctr_r   <= ctr_r + W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_counter_clock_downsample.sv
// Scoreboard bench: generic and hardened dividers driven in lockstep against a behavioural model.
module tb_counter_clock_downsample;

  localparam int unsigned W = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] val;
  logic         out_s;
  logic         out_h;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic exp_q[$];

  // Behavioural model: edges spent in current half-period, output level, shadow ratio
  int   m_ctr;
  logic m_clk;
  int   m_val_r;

  counter_clock_downsample #(.width_p(W), .harden_p(1'b0)) dut_s (
    .clk_i(clk), .reset_i(rst), .val_i(val), .clk_r_o(out_s)
  );

  counter_clock_downsample #(.width_p(W), .harden_p(1'b1)) dut_h (
    .clk_i(clk), .reset_i(rst), .val_i(val), .clk_r_o(out_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_ctr   = 0;
    m_clk   = 1'b0;
    m_val_r = 0;
  endtask

  // One rising edge: advance model, push expectation, sample both DUTs 1ns later
  task automatic tick(input string tag);
    int   cmp_v;
    logic e;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
`ifdef COUNTER_CLOCK_DOWNSAMPLE_VAL_SHADOW_EN
      cmp_v = m_val_r;
`else
      cmp_v = int'(val);
`endif
      if (m_ctr + 1 > cmp_v) begin
        m_ctr   = 0;
        m_clk   = ~m_clk;
        m_val_r = int'(val);
      end else begin
        m_ctr = m_ctr + 1;
      end
    end
    exp_q.push_back(m_clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_soft"}, out_s, e);
    chk({tag, "_hard"}, out_h, e);
  endtask

  initial begin
    logic prev;
    int   guard;
    rst = 1'b1;
    val = W'(1);
    model_reset();
    #2;
    chk("reset_async_soft", out_s, 1'b0);
    chk("reset_async_hard", out_h, 1'b0);
    repeat (3) tick("reset_held");

    // val=1: rise on 2nd edge, fall on 4th, then sustained period 4
    rst = 1'b0;
    tick("v1_e1");
    chk("v1_e1_const", out_s, 1'b0);
    tick("v1_e2");
    chk("v1_e2_rise", out_s, 1'b1);
    tick("v1_e3");
    chk("v1_e3_const", out_s, 1'b1);
    tick("v1_e4");
    chk("v1_e4_fall", out_s, 1'b0);
    repeat (100) tick("v1_run");

    // val=0: divide by 2, toggle every edge
    val = W'(0);
    tick("v0_settle");
    repeat (8) begin
      prev = m_clk;
      tick("v0_run");
      chk("v0_toggle", out_s, ~prev);
    end

    // val=max: half-period 4, counter tops out without wrap
    val = W'(3);
    repeat (24) tick("v3_run");

    // Drop ratio from 3 to 0 with the counter at 2
    guard = 0;
    while (m_ctr != 2 && guard < 16) begin
      tick("v3_seek");
      guard++;
    end
    chk("seek_ctr2_bound", 1'b1, (m_ctr == 2) ? 1'b1 : 1'b0);
    val  = W'(0);
    prev = m_clk;
    tick("drop_e1");
`ifndef COUNTER_CLOCK_DOWNSAMPLE_VAL_SHADOW_EN
    chk("drop_terminal", out_s, ~prev);
`else
    chk("drop_hold", out_s, prev);
`endif
    repeat (8) tick("drop_run");

    // Asynchronous reset mid-period while output high
    val   = W'(1);
    guard = 0;
    while (m_clk != 1'b1 && guard < 16) begin
      tick("rst_seek");
      guard++;
    end
    chk("rst_seek_high", out_s, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_soft", out_s, 1'b0);
    chk("rst_mid_hard", out_h, 1'b0);
    model_reset();
    tick("rst_held");
    rst = 1'b0;
    tick("rel_e1");
    chk("rel_e1_low", out_s, 1'b0);
    tick("rel_e2");
    chk("rel_e2_rise", out_s, 1'b1);

    // Random ratio changes: both implementations must track the model cycle-for-cycle
    repeat (300) begin
      if ($urandom_range(3, 0) == 0) val = W'($urandom_range(3, 0));
      tick("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/counter_clock_downsample.md
Name: counter_clock_downsample

Overview:
- Programmable counter-based clock divider: generates a slow square-wave clock `clk_r_o` from a fast input clock `clk_i`.
- Output half-period is `val_i+1` input cycles, so the full period is `2*(val_i+1)` input cycles.
- Used beside the DRAM controller to derive a clock-monitor clock from the 2x DFI clock; example use is width 2, `val_i`=1, giving divide-by-4.

Parameters:
- `width_p`, 2: width of the counter and of `val_i`; supported range 1..16.
- `harden_p`, 0: 0 = generic RTL flops/muxes; 1 = counter and output flop built from the team's hardened cell wrappers. Cycle behaviour must be identical for both values.

Ports:
- `clk_i`  in  1  fast input clock; all state updates on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `val_i`  in  `width_p`  divide control; half-period = `val_i+1` cycles of `clk_i`.
- `clk_r_o`  out  1  divided clock, driven directly from a flop.

Behaviour:
- State:
  - counter `ctr_r` (`width_p` bits)
  - output flop `clk_r_o`
  - optional shadow register `val_r` (see Optional Feature)
- Reset:
  - `reset_i` high clears `ctr_r` to 0 and `clk_r_o` to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while reset is held.
- Effective compare value `cmp`: equals `val_i` when the feature is off, `val_r` when it is on.
- Each rising edge of `clk_i` with reset low:
  - if `ctr_r` >= `cmp`: `ctr_r` <= 0 and `clk_r_o` <= ~`clk_r_o` (terminal count).
  - otherwise: `ctr_r` <= `ctr_r`+1.
- The >= compare is required, not ==. If `cmp` drops below the current `ctr_r`, the next edge is terminal; the counter never wraps through 2^`width_p`.
- Latency after reset deassertion: first rise of `clk_r_o` occurs on the (`cmp`+1)-th rising edge of `clk_i`.
- After that, `clk_r_o` toggles every `cmp`+1 edges, giving 50% duty cycle.
- Boundary values of `val_i`:
  - `val_i`=0: toggle on every edge (divide by 2).
  - `val_i`=2^`width_p`-1: half-period 2^`width_p` cycles; counter reaches all-ones and then returns to 0 with no overflow.
- `val_i` changes (feature off):
  - New value takes effect on the next edge compare; the in-progress half-period may be shortened or extended.
  - `clk_r_o` never toggles more than once per edge. A pulse of one `clk_i` cycle is the minimum possible.
- Reset asserted mid-period: `clk_r_o` forced to 0 asynchronously. Counting restarts from 0 after deassertion.
- Deassertion of `reset_i` is synchronised to `clk_i` by the surrounding design.
- No combinational path from any input to `clk_r_o`.
- No X propagation: all flops have a defined reset value.

Optional Feature:
- Macro: `COUNTER_CLOCK_DOWNSAMPLE_VAL_SHADOW_EN`.
- Defined:
  - Shadow register `val_r` (`width_p` bits) resets to 0 asynchronously.
  - `val_r` loads `val_i` on every terminal-count edge, at the same edge `clk_r_o` toggles.
  - Ratio changes therefore only take effect at half-period boundaries; every half-period is glitch-free and uses a single ratio.
  - First half-period after reset is 1 cycle (`val_r`=0); ratio follows `val_i` thereafter.
- Undefined:
  - No shadow register; `cmp` = `val_i` directly.
  - First half-period after reset uses `val_i`.

Test Plan:
- `width_p`=2, `val_i`=1, feature off, release reset:
  - `clk_r_o` rises on the 2nd `clk_i` edge and falls on the 4th.
  - Period 4 cycles, 50% duty, sustained over 100 cycles.
- `val_i`=0: `clk_r_o` toggles every edge (period 2).
- `val_i`=3: half-period 4 edges (period 8); `ctr_r` sequence 0,1,2,3,0 with no wrap glitch.
- Change `val_i` from 3 to 0 while `ctr_r`=2:
  - Feature off: next edge is terminal (toggle, `ctr_r`=0), then period 2.
  - Feature on: current half-period completes at `ctr_r`=3 before period 2 begins.
- Assert `reset_i` asynchronously between clock edges while `clk_r_o`=1:
  - `clk_r_o` goes 0 immediately, before the next edge.
  - After release with `val_i`=1, the first rise is on the 2nd edge.
- Run `harden_p`=0 and `harden_p`=1 with identical random `val_i` stimulus: `clk_r_o` traces must match cycle-for-cycle.
